// File: rtl/serializer.sv
// serializer: parallel-in, serial-out stage feeding a serial-in shift register.
// Holds one active word being shifted out and one queued word, so a full queue
// yields a gap-free bit stream across word boundaries while tick_i stays high.
module serializer #(
  parameter int width_p     = 5,
  parameter bit msb_first_p = 1'b0
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               tick_i,
  output logic               data_o,
  output logic               valid_o,
  output logic               shift_en_o,
  output logic               last_o,
  output logic               busy_o
);

  localparam int CNT_W = (width_p > 1) ? $clog2(width_p) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(width_p - 1);

  // Control state: IDLE means the active register is empty, SEND means it
  // holds a word whose bits are being emitted.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]         state, state_d;
  logic               hold_full, hold_full_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [width_p-1:0] act, act_d;
  logic [width_p-1:0] hold, hold_d;

  logic               act_full;
  logic               is_last;
  logic               accept;
  logic               free_act;
  logic [CNT_W-1:0]   sel;

  // Handshake and bit-strobe decode; ready depends only on registered state
  // (and the reset pin, which forces it low while reset is asserted).
  always_comb begin
    act_full   = (state == SEND);
    is_last    = act_full && (cnt == LAST_IDX);
    shift_en_o = act_full & tick_i;
    free_act   = shift_en_o & is_last;
    ready_o    = reset_n_i & ~hold_full;
    accept     = valid_i & ready_o;
  end

  // Serial output selection; data_o is forced low whenever no word is active.
  always_comb begin
    sel     = msb_first_p ? (LAST_IDX - cnt) : cnt;
    data_o  = act_full & act[sel];
    valid_o = act_full;
    last_o  = is_last;
    busy_o  = act_full | hold_full;
  end

  // Next-state logic: consume a bit on shift_en_o, then route any accepted word
  // into the active register (if empty) or the hold register (if occupied).
  always_comb begin
    state_d     = state;
    hold_full_d = hold_full;
    cnt_d       = cnt;
    act_d       = act;
    hold_d      = hold;

    if (shift_en_o) begin
      if (!is_last) begin
        cnt_d = cnt + CNT_W'(1);
      end else begin
        cnt_d = '0;
        if (hold_full) begin
          // Queued word follows with no idle cycle.
          act_d       = hold;
          hold_full_d = 1'b0;
        end else if (accept) begin
          // Word arriving on the freeing edge goes straight to active.
          act_d = data_i;
        end else begin
          state_d = IDLE;
        end
      end
    end

    if (accept && !free_act) begin
      if (!act_full) begin
        act_d   = data_i;
        cnt_d   = '0;
        state_d = SEND;
      end else begin
        hold_d      = data_i;
        hold_full_d = 1'b1;
      end
    end
  end

  // State registers; reset discards both the partial and the queued word.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      cnt       <= '0;
      act       <= '0;
      hold      <= '0;
    end else begin
      state     <= state_d;
      hold_full <= hold_full_d;
      cnt       <= cnt_d;
      act       <= act_d;
      hold      <= hold_d;
    end
  end

  // The hold register can only be occupied behind an active word.
  hold_implies_active: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) hold_full |-> act_full
  );

endmodule

// File: tb/tb_serializer.sv
// tb_serializer: drives two serializer instances (LSB-first and MSB-first) with
// identical stimulus and compares every output each cycle against a queue-based
// reference model of accepted words and the bit position within the front word.
module tb_serializer;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] data_i;
  logic         valid_i;
  logic         tick_i;

  logic ready0, data0, valid0, shen0, last0, busy0;
  logic ready1, data1, valid1, shen1, last1, busy1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: words accepted but not fully sent, and the index of the
  // next bit to send from the front word.
  logic [W-1:0] mq[$];
  int           pos = 0;

  logic         last_acc;
  int           shifts;
  logic [15:0]  sr0, sr1;

  always #5 clk = ~clk;

  serializer #(.width_p(W), .msb_first_p(1'b0)) dut_lsb (
    .clk_i(clk), .reset_n_i(rst_n), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready0), .tick_i(tick_i), .data_o(data0), .valid_o(valid0),
    .shift_en_o(shen0), .last_o(last0), .busy_o(busy0)
  );

  serializer #(.width_p(W), .msb_first_p(1'b1)) dut_msb (
    .clk_i(clk), .reset_n_i(rst_n), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready1), .tick_i(tick_i), .data_o(data1), .valid_o(valid1),
    .shift_en_o(shen1), .last_o(last1), .busy_o(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs after the falling edge, compare outputs,
  // then advance the model to reflect the coming rising edge.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic t);
    logic [W-1:0] w;
    logic         e_valid;
    logic         e_last;
    logic         e_ready;
    int           n;
    @(negedge clk);
    valid_i = v;
    data_i  = d;
    tick_i  = t;
    #1;
    n       = rst_n ? mq.size() : 0;
    e_valid = (n > 0);
    w       = e_valid ? mq[0] : '0;
    e_last  = e_valid && (pos == W - 1);
    e_ready = rst_n && (n < 2);
    chk("ready_o",     ready0, e_ready);
    chk("valid_o",     valid0, e_valid);
    chk("data_o",      data0,  e_valid ? w[pos] : 1'b0);
    chk("last_o",      last0,  e_last);
    chk("shift_en_o",  shen0,  e_valid && t);
    chk("busy_o",      busy0,  e_valid);
    chk("msb_data_o",  data1,  e_valid ? w[W-1-pos] : 1'b0);
    chk("msb_last_o",  last1,  e_last);
    chk("msb_ready_o", ready1, e_ready);
    last_acc = 1'b0;
    if (rst_n) begin
      last_acc = v && (n < 2);
      if (e_valid && t) begin
        sr0 = {sr0[14:0], data0};
        sr1 = {sr1[14:0], data1};
        shifts++;
        if (e_last) begin
          void'(mq.pop_front());
          pos = 0;
        end else begin
          pos++;
        end
      end
      if (last_acc) mq.push_back(d);
    end
  endtask

  task automatic clear_capture();
    sr0    = '0;
    sr1    = '0;
    shifts = 0;
  endtask

  initial begin
    logic [W-1:0] pend;
    logic         have;
    int           acc_at;
    int           acc_cnt;

    rst_n   = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    tick_i  = 1'b0;
    clear_capture();

    // Reset state
    cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 5'b11111, 1'b1);
    valid_i = 1'b0;
    @(negedge clk); #2; rst_n = 1'b1;

    // Single word, LSB first and MSB first in parallel
    clear_capture();
    cycle(1'b1, 5'b10110, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1);
    chk("single_shifts", shifts, 5);
    chk("single_lsb_sr", sr0[4:0], 5'b01101);
    chk("single_msb_sr", sr1[4:0], 5'b10110);

    // Back-to-back words with no gap
    clear_capture();
    cycle(1'b1, 5'b00001, 1'b1);
    cycle(1'b1, 5'b11110, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b0, '0, 1'b1);
    chk("b2b_shifts", shifts, 10);
    chk("b2b_stream", sr0[9:0], 10'b1000001111);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);

    // Tick gating: one tick every third cycle
    clear_capture();
    cycle(1'b1, 5'b10101, 1'b0);
    for (int i = 0; i < 18; i++) cycle(1'b0, '0, (i % 3) == 2);
    chk("tick_shifts", shifts, 5);
    chk("tick_stream", sr0[4:0], 5'b10101);

    // MSB first
    clear_capture();
    cycle(1'b1, 5'b10000, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
    chk("msb_stream", sr1[4:0], 5'b10000);

    // Backpressure: hold register full, 5'b11111 presented until taken
    clear_capture();
    cycle(1'b1, 5'b01001, 1'b1);
    cycle(1'b1, 5'b00110, 1'b1);
    acc_at  = -1;
    acc_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (acc_cnt == 0) cycle(1'b1, 5'b11111, 1'b1);
      else              cycle(1'b0, '0, 1'b1);
      if (last_acc) begin
        acc_cnt++;
        if (acc_at < 0) acc_at = i;
      end
    end
    chk("bp_accept_cycle", acc_at, 4);
    chk("bp_accept_count", acc_cnt, 1);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
    chk("bp_shifts", shifts, 15);
    chk("bp_last_word", sr0[4:0], 5'b11111);

    // Reset mid-word with the hold register full
    cycle(1'b1, 5'b11011, 1'b1);
    cycle(1'b1, 5'b01010, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    @(negedge clk); #2; rst_n = 1'b0; #1;
    chk("rst_valid_o",    valid0, 1'b0);
    chk("rst_data_o",     data0,  1'b0);
    chk("rst_last_o",     last0,  1'b0);
    chk("rst_shift_en_o", shen0,  1'b0);
    chk("rst_busy_o",     busy0,  1'b0);
    chk("rst_ready_o",    ready0, 1'b0);
    mq.delete();
    pos = 0;
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    @(negedge clk); #2; rst_n = 1'b1;
    clear_capture();
    cycle(1'b1, 5'b00111, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
    chk("post_rst_shifts", shifts, 5);
    chk("post_rst_stream", sr0[4:0], 5'b11100);

    // Randomized traffic; upstream keeps a word presented until it is taken
    have = 1'b0;
    pend = '0;
    for (int i = 0; i < 400; i++) begin
      if (!have && ($urandom_range(0, 9) < 7)) begin
        pend = W'($urandom);
        have = 1'b1;
      end
      cycle(have, have ? pend : '0, $urandom_range(0, 9) < 6);
      if (last_acc) have = 1'b0;
    end
    for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b1);
    chk("rand_drained", busy0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
